dep_issue_queue: RTL and testbench
==================================

# dep_issue_queue

Dependency-matrix issue stage directly downstream of the instruction register table (IRT). It captures the per-instruction dependency vector the IRT produces for each buffer slot, tracks which older slots are still outstanding, and issues slots whose dependencies have all completed, one per cycle, through a valid/ready handshake. Completion notifications from execution clear matrix columns and free slots for reuse.

## Interface
- BS, 16: instruction-buffer slots; power of two, ≥2.
- IW, $clog2(BS): slot-index width (derived, not overridable).

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- alloc_valid  in  1  new instruction written to slot alloc_idx this cycle.
- alloc_idx  in  IW  slot being allocated (same index the IRT received one cycle earlier).
- alloc_dep  in  BS  IRT dependency vector; bit k=1 means the instruction depends on slot k.
- issue_valid  out  1  issue_idx holds a ready slot.
- issue_idx  out  IW  slot being issued.
- issue_ready  in  1  execution accepts issue_idx this cycle.
- complete_valid  in  1  slot complete_idx finished execution.
- complete_idx  in  IW  completing slot.
- occupancy  out  IW+1  number of valid slots.
- err  out  1  sticky protocol-error flag.

## Operation
- Per-slot state: valid, issued, dep[BS].
- Per-cycle update order: completion, then allocation, then issue load.
- Completion (complete_valid, slot valid and issued): clear column complete_idx in every row; clear valid and issued of that slot. Completion of a non-valid or non-issued slot is ignored and sets err.
- Allocation (alloc_valid): if the slot is still valid after the completion step, the allocation is ignored and err is set. Otherwise: valid=1, issued=0, dep = alloc_dep & valid_after_completion & ~onehot(alloc_idx). Dependencies on empty or just-completed slots are therefore dropped.
- Ready slot: valid & ~issued & (dep==0), evaluated on registered state only. Same-cycle completions and allocations become visible the next cycle.
- Output register: loaded when empty or accepted (issue_valid & issue_ready). The load takes the first ready slot at or after rr_ptr, wrapping modulo BS. The loaded slot's issued bit is set at the same edge, so a slot is never picked twice.
- After each load of slot k: rr_ptr = (k+1) mod BS. rr_ptr is unchanged when nothing is loaded.
- If the output register is empty or accepted and no slot is ready: issue_valid=0 next cycle.
- occupancy = popcount(valid), registered, tracking the state after each edge.
- err is cleared only by rst.

## Timing
- Reset values: issue_valid=0, issue_idx=0, occupancy=0, err=0, rr_ptr=0, all valid/issued/dep=0. Reset mid-operation discards all slots and any pending issue immediately.
- Alloc latency: slot allocated at edge N with dep=0 → issue_valid=1 with that index after edge N+1.
- Wake-up latency: completion of the last producer at edge N → consumer issue_valid after edge N+1.
- Handshake: while issue_valid=1 and issue_ready=0, issue_valid and issue_idx hold stable. After acceptance, the next ready slot can appear in the following cycle, giving back-to-back issue at 1/cycle.
- Completion and allocation of the same index in the same cycle is legal: the slot is freed then reused, and the new row has no self-dependency.
- Completion of a slot whose column bit is set in the row being allocated that cycle: the bit is masked, so no stale dependency is created.
- occupancy is bounded at BS. Allocation when full is rejected only via the valid-slot check above.

## Structure
- Shared package esm_pkg holds BS default, an IW helper function, and the slot-state struct (valid, issued, dep).
- One sub-module, rr_pick: combinational rotating-priority picker with inputs req[BS] and ptr[IW], and outputs gnt_valid and gnt_idx[IW]. It is reused by later issue-width extensions.
- Dependency matrix, column clear, output register, and err logic live in dep_issue_queue.

## Test plan
- Reset then allocate slot 3 with alloc_dep=0, issue_ready=1 → issue_valid=1, issue_idx=3 two cycles after alloc. occupancy=1, err=0.
- Allocate slot 0 (dep=0) and slot 1 (dep=0x0001) → slot 0 issues. Complete 0 → slot 1 issues exactly one cycle after the completion edge.
- Allocate slot 5 with alloc_dep=0x0030 while slots 4 and 5 are empty → dep masked to 0, slot 5 issues immediately. No self-dependency.
- Hold issue_ready=0 with slots 2, 6, 9 ready, rr_ptr=7 → issue_idx=9 held stable. After release, the order is 9, 2, 6.
- Complete slot 4 and allocate slot 4 in the same cycle → occupancy unchanged, the new slot 4 issues, err=0. Allocate slot 4 again while valid → ignored, err=1.
- Assert rst while issue_valid=1 with 3 slots pending → all outputs return to reset values. A new allocation behaves as after the first reset.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared definitions for the dependency-matrix issue stage: default buffer
// depth, slot-index width helper and the per-slot state record.
package esm_pkg;

    localparam int BS_DEF = 16;

    // Slot-index width for a buffer of bs entries (at least one bit).
    function automatic int iw_of(input int bs);
        return (bs > 32'sd1) ? $clog2(bs) : 32'sd1;
    endfunction

    // Per-slot state as held by the issue stage at the default depth.
    typedef struct packed {
        logic              valid;
        logic              issued;
        logic [BS_DEF-1:0] dep;
    } slot_t;

endpackage

// File: rtl/dep_issue_queue_rr_pick.sv
// Rotating-priority picker: grants the first requesting index at or after
// ptr, wrapping modulo BS. Purely combinational.
module rr_pick
    import esm_pkg::*;
#(
    parameter  int BS = BS_DEF,
    localparam int IW = iw_of(BS)
) (
    input  logic [BS-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand_s;

    // Scan from ptr upward; the first hit wins and later hits are ignored.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand_s    = '0;
        for (int o = 0; o < BS; o++) begin
            cand_s = ptr + IW'(o);
            if (!gnt_valid && req[cand_s]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_s;
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/dep_issue_queue.sv
// Dependency-matrix issue stage. Each slot keeps a row of producer bits;
// completions clear a column, and slots whose row is empty are issued one
// per cycle through a registered valid/ready output.
module dep_issue_queue
    import esm_pkg::*;
#(
    parameter  int BS = BS_DEF,
    localparam int IW = iw_of(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    input  logic [IW-1:0] alloc_idx,
    input  logic [BS-1:0] alloc_dep,
    output logic          issue_valid,
    output logic [IW-1:0] issue_idx,
    input  logic          issue_ready,
    input  logic          complete_valid,
    input  logic [IW-1:0] complete_idx,
    output logic [IW:0]   occupancy,
    output logic          err
);

    localparam logic [IW-1:0] ONE_IW = IW'(1);

    // Number of set bits in a slot-valid vector.
    function automatic logic [IW:0] popcount(input logic [BS-1:0] v);
        logic [IW:0] c;
        c = '0;
        for (int i = 0; i < BS; i++) begin
            c = c + {{IW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [BS-1:0] valid_r, issued_r;
    logic [BS-1:0] dep_r [BS];
    logic [BS-1:0] valid_s, issued_s;
    logic [BS-1:0] dep_s [BS];
    logic [BS-1:0] valid_mid_s;
    logic [BS-1:0] onehot_s;
    logic [BS-1:0] req_s;
    logic [IW-1:0] rr_ptr_r, rr_ptr_s;
    logic          issue_valid_r, issue_valid_s;
    logic [IW-1:0] issue_idx_r, issue_idx_s;
    logic [IW:0]   occupancy_r, occupancy_s;
    logic          err_r, err_s;
    logic          comp_ok_s;
    logic          load_s;
    logic          gnt_valid_s;
    logic [IW-1:0] gnt_idx_s;

    // Ready vector from registered state only, so same-cycle updates wait a cycle.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < BS; i++) begin
            req_s[i] = valid_r[i] & ~issued_r[i] & ~(|dep_r[i]);
        end
    end

    rr_pick #(
        .BS(BS)
    ) u_pick (
        .req       (req_s),
        .ptr       (rr_ptr_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Next-state: completion first, then allocation, then output-register load.
    always_comb begin
        valid_s       = valid_r;
        issued_s      = issued_r;
        dep_s         = dep_r;
        rr_ptr_s      = rr_ptr_r;
        issue_valid_s = issue_valid_r;
        issue_idx_s   = issue_idx_r;
        err_s         = err_r;
        onehot_s      = '0;
        onehot_s[alloc_idx] = 1'b1;

        comp_ok_s = complete_valid & valid_r[complete_idx] & issued_r[complete_idx];
        if (comp_ok_s) begin
            for (int i = 0; i < BS; i++) begin
                dep_s[i][complete_idx] = 1'b0;
            end
            valid_s[complete_idx]  = 1'b0;
            issued_s[complete_idx] = 1'b0;
        end else if (complete_valid) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end

        // Dependencies are masked against slots still live after completion,
        // which also drops a bit for a producer completing this very cycle.
        valid_mid_s = valid_s;
        if (alloc_valid) begin
            if (valid_mid_s[alloc_idx]) begin
                err_s = 1'b1;
            end else begin
                valid_s[alloc_idx]  = 1'b1;
                issued_s[alloc_idx] = 1'b0;
                dep_s[alloc_idx]    = alloc_dep & valid_mid_s & ~onehot_s;
            end
        end else begin
            err_s = err_s;
        end

        // A picked slot is valid and un-issued in registered state, so neither
        // a legal completion nor a legal allocation can target it this cycle.
        load_s = ~issue_valid_r | issue_ready;
        if (load_s) begin
            issue_valid_s = gnt_valid_s;
            if (gnt_valid_s) begin
                issued_s[gnt_idx_s] = 1'b1;
                issue_idx_s         = gnt_idx_s;
                rr_ptr_s            = gnt_idx_s + ONE_IW;
            end else begin
                issue_idx_s = issue_idx_r;
            end
        end else begin
            issue_valid_s = issue_valid_r;
        end

        occupancy_s = popcount(valid_s);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r       <= '0;
            issued_r      <= '0;
            for (int i = 0; i < BS; i++) begin
                dep_r[i] <= '0;
            end
            rr_ptr_r      <= '0;
            issue_valid_r <= 1'b0;
            issue_idx_r   <= '0;
            occupancy_r   <= '0;
            err_r         <= 1'b0;
        end else begin
            valid_r       <= valid_s;
            issued_r      <= issued_s;
            for (int i = 0; i < BS; i++) begin
                dep_r[i] <= dep_s[i];
            end
            rr_ptr_r      <= rr_ptr_s;
            issue_valid_r <= issue_valid_s;
            issue_idx_r   <= issue_idx_s;
            occupancy_r   <= occupancy_s;
            err_r         <= err_s;
        end
    end

    assign issue_valid = issue_valid_r;
    assign issue_idx   = issue_idx_r;
    assign occupancy   = occupancy_r;
    assign err         = err_r;

endmodule

// File: tb/tb_dep_issue_queue.sv
// Directed bench for dep_issue_queue: hand-computed expectations checked a
// short delay after each rising edge.
module tb_dep_issue_queue;

    localparam int BS = 16;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          alloc_valid;
    logic [IW-1:0] alloc_idx;
    logic [BS-1:0] alloc_dep;
    logic          issue_valid;
    logic [IW-1:0] issue_idx;
    logic          issue_ready;
    logic          complete_valid;
    logic [IW-1:0] complete_idx;
    logic [IW:0]   occupancy;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    dep_issue_queue #(.BS(BS)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_idx      (alloc_idx),
        .alloc_dep      (alloc_dep),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .issue_ready    (issue_ready),
        .complete_valid (complete_valid),
        .complete_idx   (complete_idx),
        .occupancy      (occupancy),
        .err            (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input int ai, input logic [BS-1:0] ad,
                         input logic cv, input int ci);
        alloc_valid    = av;
        alloc_idx      = IW'(ai);
        alloc_dep      = ad;
        complete_valid = cv;
        complete_idx   = IW'(ci);
    endtask

    task automatic idle();
        drive(1'b0, 0, 16'h0000, 1'b0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        issue_ready = 1'b0;
        idle();
        repeat (2) tick();
        check_eq("rst_iv",  32'(issue_valid), 32'd0);
        check_eq("rst_idx", 32'(issue_idx),   32'd0);
        check_eq("rst_occ", 32'(occupancy),   32'd0);
        check_eq("rst_err", 32'(err),         32'd0);
        rst = 1'b0;

        // Single allocation, two-edge latency to issue.
        issue_ready = 1'b1;
        drive(1'b1, 3, 16'h0000, 1'b0, 0); tick();
        idle();
        check_eq("t1_iv_early", 32'(issue_valid), 32'd0);
        check_eq("t1_occ",      32'(occupancy),   32'd1);
        tick();
        check_eq("t1_iv",  32'(issue_valid), 32'd1);
        check_eq("t1_idx", 32'(issue_idx),   32'd3);
        check_eq("t1_err", 32'(err),         32'd0);
        drive(1'b0, 0, 16'h0000, 1'b1, 3); tick();
        idle();
        check_eq("t1_iv_drain", 32'(issue_valid), 32'd0);
        check_eq("t1_occ_free", 32'(occupancy),   32'd0);

        // Consumer wakes one edge after its producer completes.
        drive(1'b1, 0, 16'h0000, 1'b0, 0); tick();
        drive(1'b1, 1, 16'h0001, 1'b0, 0); tick();
        idle();
        check_eq("t2_iv0",  32'(issue_valid), 32'd1);
        check_eq("t2_idx0", 32'(issue_idx),   32'd0);
        check_eq("t2_occ",  32'(occupancy),   32'd2);
        drive(1'b0, 0, 16'h0000, 1'b1, 0); tick();
        idle();
        check_eq("t2_blocked", 32'(issue_valid), 32'd0);
        check_eq("t2_occ1",    32'(occupancy),   32'd1);
        tick();
        check_eq("t2_iv1",  32'(issue_valid), 32'd1);
        check_eq("t2_idx1", 32'(issue_idx),   32'd1);
        drive(1'b0, 0, 16'h0000, 1'b1, 1); tick();
        idle();
        check_eq("t2_iv_end",  32'(issue_valid), 32'd0);
        check_eq("t2_occ_end", 32'(occupancy),   32'd0);
        check_eq("t2_err",     32'(err),         32'd0);

        // Dependencies on empty slots and on itself are dropped.
        drive(1'b1, 5, 16'h0030, 1'b0, 0); tick();
        idle();
        check_eq("t3_iv_early", 32'(issue_valid), 32'd0);
        tick();
        check_eq("t3_iv",  32'(issue_valid), 32'd1);
        check_eq("t3_idx", 32'(issue_idx),   32'd5);
        drive(1'b0, 0, 16'h0000, 1'b1, 5); tick();
        idle();
        check_eq("t3_occ", 32'(occupancy), 32'd0);

        // Build ready set {2,6,9} with rr_ptr=7 and the output register empty.
        issue_ready = 1'b0;
        drive(1'b1, 6, 16'h0000, 1'b0, 0); tick();
        drive(1'b1, 2, 16'h0040, 1'b0, 0); tick();
        check_eq("t4_idx6", 32'(issue_idx), 32'd6);
        drive(1'b1, 9, 16'h0040, 1'b0, 0); tick();
        issue_ready = 1'b1;
        drive(1'b1, 6, 16'h0000, 1'b1, 6); tick();
        idle();
        check_eq("t4_iv_gap", 32'(issue_valid), 32'd0);
        check_eq("t4_occ3",   32'(occupancy),   32'd3);
        issue_ready = 1'b0;
        tick();
        check_eq("t4_iv9",  32'(issue_valid), 32'd1);
        check_eq("t4_idx9", 32'(issue_idx),   32'd9);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("t4_hold_iv",  32'(issue_valid), 32'd1);
            check_eq("t4_hold_idx", 32'(issue_idx),   32'd9);
        end
        issue_ready = 1'b1;
        tick();
        check_eq("t4_idx2", 32'(issue_idx), 32'd2);
        tick();
        check_eq("t4_idx6b", 32'(issue_idx), 32'd6);
        tick();
        check_eq("t4_iv_done", 32'(issue_valid), 32'd0);
        drive(1'b0, 0, 16'h0000, 1'b1, 2); tick();
        drive(1'b0, 0, 16'h0000, 1'b1, 6); tick();
        drive(1'b0, 0, 16'h0000, 1'b1, 9); tick();
        idle();
        check_eq("t4_occ0", 32'(occupancy), 32'd0);
        check_eq("t4_err",  32'(err),       32'd0);

        // Same-cycle completion and reuse of slot 4, then an illegal reallocation.
        drive(1'b1, 4, 16'h0000, 1'b0, 0); tick();
        idle(); tick();
        check_eq("t5_idx4", 32'(issue_idx), 32'd4);
        drive(1'b1, 4, 16'h0010, 1'b1, 4); tick();
        idle();
        check_eq("t5_occ",   32'(occupancy),   32'd1);
        check_eq("t5_iv",    32'(issue_valid), 32'd0);
        check_eq("t5_err0",  32'(err),         32'd0);
        tick();
        check_eq("t5_iv_new",  32'(issue_valid), 32'd1);
        check_eq("t5_idx_new", 32'(issue_idx),   32'd4);
        drive(1'b1, 4, 16'h0000, 1'b0, 0); tick();
        idle();
        check_eq("t5_err1",    32'(err),       32'd1);
        check_eq("t5_occ_rej", 32'(occupancy), 32'd1);
        tick();
        check_eq("t5_err_sticky", 32'(err), 32'd1);

        // Reset while an issue is pending and three slots wait.
        issue_ready = 1'b0;
        drive(1'b1, 1, 16'h0000, 1'b0, 0); tick();
        drive(1'b1, 2, 16'h0000, 1'b0, 0); tick();
        drive(1'b1, 3, 16'h0000, 1'b0, 0); tick();
        idle();
        check_eq("t6_iv_pre",  32'(issue_valid), 32'd1);
        check_eq("t6_idx_pre", 32'(issue_idx),   32'd1);
        check_eq("t6_occ_pre", 32'(occupancy),   32'd4);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_iv",  32'(issue_valid), 32'd0);
        check_eq("t6_rst_idx", 32'(issue_idx),   32'd0);
        check_eq("t6_rst_occ", 32'(occupancy),   32'd0);
        check_eq("t6_rst_err", 32'(err),         32'd0);
        rst = 1'b0;
        issue_ready = 1'b1;
        tick();
        drive(1'b1, 3, 16'h0000, 1'b0, 0); tick();
        idle();
        check_eq("t6_iv_early", 32'(issue_valid), 32'd0);
        check_eq("t6_occ",      32'(occupancy),   32'd1);
        tick();
        check_eq("t6_iv",  32'(issue_valid), 32'd1);
        check_eq("t6_idx", 32'(issue_idx),   32'd3);
        check_eq("t6_err", 32'(err),         32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
